// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches from the current PC,
// buffers returned words in a small FIFO and flushes/restarts on redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr_code,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  output logic [CW-1:0] count,
  output logic          fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, BLOCKED, FAULT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          imem_req_q, imem_req_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [31:0]   code_q [DEPTH];
  logic [31:0]   code_d [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic [AW-1:0] pc_d   [DEPTH];

  logic push, pop;

  // Next-state: FIFO bookkeeping, fetch sequencing, redirect flush on top
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    code_d       = code_q;
    pc_d         = pc_q;

    push = imem_req_q & imem_ack;
    pop  = valid_q & instr_ready;

    if (push && !redirect) begin
      code_d[wr_ptr_q] = imem_rdata;
      pc_d[wr_ptr_q]   = fetch_addr_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      fetch_addr_d     = fetch_addr_q + AW'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (push && count_d == FULL) state_d = BLOCKED;
      // Resume only once the registered count has shown room
      BLOCKED: if (count_q < FULL) state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = pc_in;
      state_d      = (pc_in[1:0] == 2'b00) ? FETCH : FAULT;
    end

    imem_req_d = (state_d == FETCH);
    fault_d    = (state_d == FAULT);
    valid_d    = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      imem_req_q   <= 1'b0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= '{default: '0};
      pc_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      imem_req_q   <= imem_req_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      pc_q         <= pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = {fetch_addr_q[AW-1:2], 2'b00};
  assign instr_valid = valid_q;
  assign instr_code  = code_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign count       = count_q;
  assign fault       = fault_q;

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Consumer end of the program-counter path: takes the PC value as the fetch start point and issues sequential word fetches to instruction memory.
- Buffers the returned instruction words in a small FIFO and hands them to decode over a valid/ready interface.
- When the PC unit redirects (taken branch or jump), the block flushes all buffered words and restarts fetching at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, address/PC width.
- CW, 3, width of occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pc_in  in  AW  new fetch address; sampled only when redirect=1.
- redirect  in  1  single-cycle pulse: load pc_in and flush the queue.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  AW  fetch address; word-aligned.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  queue head valid.
- instr_code  out  32  queue head instruction.
- instr_pc  out  AW  address of the queue head instruction.
- instr_ready  in  1  decode consumes the head.
- count  out  CW  current FIFO occupancy.
- fault  out  1  misaligned redirect target.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, fetch_addr=0, FIFO pointers=0, count=0.
  - imem_req=0, instr_valid=0, fault=0.
  - instr_code and instr_pc are 0.
  - Reset overrides every other input, including mid-handshake.
- FSM states: IDLE, FETCH, BLOCKED, FAULT.
  - IDLE: imem_req=0. Unconditionally goes to FETCH on the next cycle. A redirect in IDLE is still honoured.
  - FETCH: imem_req=1, imem_addr=fetch_addr.
    - Accept = imem_req & imem_ack.
    - On accept: push {imem_rdata, fetch_addr}; fetch_addr <= fetch_addr+4 (mod 2^AW, so 0xFFFFFFFC wraps to 0).
    - If the post-update count equals DEPTH, go to BLOCKED.
  - BLOCKED: imem_req=0. Returns to FETCH in the cycle after count drops below DEPTH.
  - FAULT: imem_req=0, fault=1. Left only by an aligned redirect (goes to FETCH, fault=0) or by reset.
- imem_req and imem_addr stay stable until ack, except on redirect. A redirect may withdraw or change an unacknowledged request.
- Request gating: imem_req uses the registered count only. There is no same-cycle pop bypass, so a full queue never issues a request even while popping.
- Pop: occurs when instr_valid & instr_ready. instr_valid = (count != 0). The head is registered FIFO output, with no combinational path from imem_rdata.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Redirect has priority over push and pop in the same cycle:
  - Any word acknowledged in that cycle is discarded.
  - A pop in that cycle counts as consumed.
  - Next cycle: count=0, instr_valid=0, fetch_addr=pc_in.
  - State becomes FETCH if pc_in[1:0]==0, otherwise FAULT.
- Redirect latency: imem_addr shows the new target, with imem_req=1, in the first cycle after the redirect edge.
- Throughput: 1 instruction per cycle with imem_ack held at 1 and instr_ready held at 1.
- count never exceeds DEPTH. No push is possible when full, because imem_req=0.

Test Plan:
1. Sequential fetch. Setup: reset low 2 cycles then high; imem_ack=1; memory returns word = 0xA000_0000|addr; instr_ready=1. Required: imem_req rises 1 cycle after IDLE; instr_pc sequence 0,4,8,12; instr_code 0xA0000000, 0xA0000004, …; no gaps.
2. Backpressure. Setup: instr_ready=0, DEPTH=4. Required: after 4 acks, count=4 and state is BLOCKED with imem_req=0. Then pulse instr_ready for 1 cycle: count=3, and imem_req=1 on the following cycle at addr 0x10.
3. Redirect while full. Setup: queue full; redirect=1, pc_in=0x40, instr_ready=1 in the same cycle. Required: next cycle count=0, instr_valid=0, imem_addr=0x40, imem_req=1. The first word delivered afterwards has instr_pc=0x40.
4. Redirect against an ack. Setup: redirect=1 to 0x100 in a cycle where imem_ack=1 at addr 0x8. Required: the word from 0x8 never appears on instr_code; the next instr_pc is 0x100.
5. Misaligned target and wrap. Setup: redirect to 0x42. Required: fault=1, imem_req=0 indefinitely. Then redirect to 0xFFFFFFFC. Required: fault=0, fetches 0xFFFFFFFC then 0x00000000.
6. Reset mid-operation. Setup: reset=0 while imem_req=1, imem_ack=0 and count=2. Required: next cycle all outputs at reset values (count=0, imem_req=0); fetch restarts at address 0.
